// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter for the serial system bus.
// Grants one master at a time, drives the master-select mux, follows the
// serial handshake to find the end of each transaction and releases the
// grant after one complete transaction or after a bus timeout.
module bus_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic breq1,
  input  logic breq2,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel,
  input  logic mvalid,
  input  logic smode,
  input  logic svalid,
  output logic bus_busy,
  output logic timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] AW      = 8'(ADDR_WIDTH);
  localparam logic [7:0] DW      = 8'(DATA_WIDTH);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);
  localparam bit         NO_DATA = (DATA_WIDTH == 0);
  localparam bit         ONE_ADDR = (ADDR_WIDTH == 1);

  state_t     state, state_d;
  logic [7:0] bitcnt, bitcnt_d;
  logic [7:0] tocnt, tocnt_d;
  logic       mode_q, mode_d;
  logic       last, last_d;
  logic       msel_d;
  logic       timeout_d;
  logic       pick2;
  logic       strobe;
  logic       in_xfer;
  logic       active_d;

  // Next-state, counter and output-next computation; all outputs are registered.
  always_comb begin
    state_d   = state;
    bitcnt_d  = bitcnt;
    tocnt_d   = '0;
    mode_d    = mode_q;
    last_d    = last;
    msel_d    = msel;
    timeout_d = 1'b0;
    pick2     = 1'b0;
    strobe    = 1'b0;
    in_xfer   = 1'b0;

    case (state)
      IDLE: begin
        if (breq1 || breq2) begin
          // Master 2 wins when alone, or on a tie when master 1 was served last.
          pick2    = breq2 && (!breq1 || !last);
          msel_d   = pick2;
          last_d   = pick2;
          bitcnt_d = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (!(msel ? breq2 : breq1)) begin
          state_d = DONE;
        end else if (mvalid) begin
          mode_d = smode;
          if (ONE_ADDR) begin
            bitcnt_d = '0;
            state_d  = NO_DATA ? DONE : (smode ? WDATA : RDATA);
          end else begin
            bitcnt_d = 8'd1;
            state_d  = ADDR;
          end
        end
      end
      ADDR: begin
        in_xfer = 1'b1;
        strobe  = mvalid;
        if (mvalid) begin
          if (bitcnt + 8'd1 == AW) begin
            bitcnt_d = '0;
            state_d  = NO_DATA ? DONE : (mode_q ? WDATA : RDATA);
          end else begin
            bitcnt_d = bitcnt + 8'd1;
          end
        end
      end
      WDATA: begin
        in_xfer = 1'b1;
        strobe  = mvalid;
        if (mvalid) begin
          if (bitcnt + 8'd1 == DW) begin
            bitcnt_d = '0;
            state_d  = DONE;
          end else begin
            bitcnt_d = bitcnt + 8'd1;
          end
        end
      end
      RDATA: begin
        in_xfer = 1'b1;
        strobe  = svalid;
        if (svalid) begin
          if (bitcnt + 8'd1 == DW) begin
            bitcnt_d = '0;
            state_d  = DONE;
          end else begin
            bitcnt_d = bitcnt + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Idle-gap watchdog: the cycle whose increment would reach TIMEOUT-1 aborts,
    // so DONE (and the timeout pulse) lands in the TIMEOUT-th idle cycle.
    if (in_xfer && !strobe) begin
      if (tocnt == TO_LAST) begin
        timeout_d = 1'b1;
        bitcnt_d  = '0;
        state_d   = DONE;
      end else begin
        tocnt_d = tocnt + 8'd1;
      end
    end

    active_d = (state_d == GRANT) || (state_d == ADDR) ||
               (state_d == WDATA) || (state_d == RDATA);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      bitcnt   <= '0;
      tocnt    <= '0;
      mode_q   <= 1'b0;
      last     <= 1'b1;
      msel     <= 1'b0;
      bgrant1  <= 1'b0;
      bgrant2  <= 1'b0;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      bitcnt   <= bitcnt_d;
      tocnt    <= tocnt_d;
      mode_q   <= mode_d;
      last     <= last_d;
      msel     <= msel_d;
      bgrant1  <= active_d & ~msel_d;
      bgrant2  <= active_d & msel_d;
      bus_busy <= active_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed, table-driven checks of the two-master bus arbiter.
// Observed vector is {bgrant1, bgrant2, msel, bus_busy, timeout}.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rstn, breq1, breq2, mvalid, smode, svalid;
  logic bgrant1, bgrant2, msel, bus_busy, timeout;
  logic [4:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       r;
    logic       b1;
    logic       b2;
    logic       mv;
    logic       sm;
    logic       sv;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[12];

  bus_arbiter #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .breq1(breq1),
    .breq2(breq2),
    .bgrant1(bgrant1),
    .bgrant2(bgrant2),
    .msel(msel),
    .mvalid(mvalid),
    .smode(smode),
    .svalid(svalid),
    .bus_busy(bus_busy),
    .timeout(timeout)
  );

  assign outs = {bgrant1, bgrant2, msel, bus_busy, timeout};

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, expected summary before it");
    $fatal(1, "time limit");
  end

  // Drive inputs, take one rising edge, settle past it.
  task automatic cyc(input logic r, b1, b2, mv, sm, sv);
    rstn = r; breq1 = b1; breq2 = b2; mvalid = mv; smode = sm; svalid = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] exp);
    n_tests++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (g1 g2 msel busy to)", name, outs, exp);
    end
  endtask

  function automatic logic [4:0] granted(input logic m);
    return m ? 5'b01110 : 5'b10010;
  endfunction

  function automatic logic [4:0] released(input logic m);
    return {2'b00, m, 2'b00};
  endfunction

  // Full write of 12 address + 8 data strobes starting from GRANT held by m.
  task automatic write_txn(input logic b1f, b2f, b1r, b2r, input logic m);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) cyc(1'b1, b1f, b2f, 1'b1, 1'b1, 1'b0);
      else        cyc(1'b1, b1r, b2r, 1'b1, 1'b1, 1'b0);
      if (i < 19) chk("wr_hold", granted(m));
      else        chk("wr_drop", released(m));
    end
  endtask

  initial begin
    rstn = 1'b0; breq1 = 1'b0; breq2 = 1'b0;
    mvalid = 1'b0; smode = 1'b0; svalid = 1'b0;
    @(posedge clk); #1;

    // Reset values, withdrawn request, round-robin bookkeeping of last.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10010};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10010};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01110};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10010};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].b1, tbl[i].b2, tbl[i].mv, tbl[i].sm, tbl[i].sv);
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // GRANT has no timeout: hold the request well past TIMEOUT without strobes.
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("grant_no_to", 5'b10010);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("grant_wd_done", 5'b00000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("grant_wd_idle", 5'b00000);

    // Single-master write; request dropped after the first strobe is ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_grant", 5'b10010);
    write_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_idle", 5'b00000);

    // Both requests held after reset: four alternating grants, 2-cycle dead time.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b_reset", 5'b00000);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rr_grant", granted(1'b0));
    for (int g = 0; g < 4; g++) begin
      logic m;
      m = (g % 2 == 1);
      write_txn(1'b1, 1'b1, 1'b1, 1'b1, m);
      if (g < 3) begin
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rr_idle", released(m));
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rr_grant", granted(!m));
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rr_end", 5'b00100);

    // Read by master 2: stray mvalid in the turnaround gap must not count.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd_grant", 5'b01110);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, (i == 0), 1'b1, 1'b0, 1'b0);
      chk("rd_addr", 5'b01110);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rd_gap", 5'b01110);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk(i < 7 ? "rd_data" : "rd_drop", i < 7 ? 5'b01110 : 5'b00100);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rd_idle", 5'b00100);

    // Timeout: 5 address bits then silence; master 2 waits.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_grant", 5'b10010);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("to_addr", 5'b10010);
    end
    for (int j = 1; j <= 15; j++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk(j < 15 ? "to_wait" : "to_pulse", j < 15 ? 5'b10010 : 5'b00001);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_idle", 5'b00000);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_regrant", 5'b01110);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_wd_done", 5'b00100);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_wd_idle", 5'b00100);

    // Reset during the third write-data bit drops the grant at once.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_grant", 5'b10010);
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("rst_xfer", 5'b10010);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_mid", 5'b00000);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_regrant", 5'b01110);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_wd_done", 5'b00100);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_wd_idle", 5'b00100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
